// File: rtl/vram_arbiter.sv
// Framebuffer write-port arbiter: CPU stores and a block-fill engine share one
// registered write port, with round-robin priority when both want the same cycle.
module vram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clki,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    output logic          cpu_ack,
    input  logic          clr_start,
    input  logic [AW-1:0] clr_base,
    input  logic [AW-1:0] clr_len,
    input  logic [DW-1:0] clr_value,
    output logic          clr_busy,
    output logic          clr_done,
    input  logic          vram_rdy,
    output logic          vga_we,
    output logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic          prio_q, prio_d;
    logic          we_q, we_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] base_q, len_q;
    logic [DW-1:0] value_q;
    logic          load, cpu_v, fill_v, gnt_cpu, gnt_fill;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            prio_q  <= prio_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Fill parameters are only consumed after an accepted start, so they need no reset.
    always_ff @(posedge clki) begin
        if (load) begin
            base_q  <= clr_base;
            len_q   <= clr_len;
            value_q <= clr_value;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        prio_d  = prio_q;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        load    = 1'b0;

        // The ack cycle masks the still-high request of the write just issued.
        cpu_v    = cpu_req && !ack_q;
        fill_v   = (state_q == FILL);
        gnt_cpu  = vram_rdy && cpu_v && (!fill_v || !prio_q);
        gnt_fill = vram_rdy && fill_v && (!cpu_v || prio_q);

        if (vram_rdy && cpu_v && fill_v) begin
            prio_d = ~prio_q;
        end

        if (gnt_cpu) begin
            we_d   = 1'b1;
            ack_d  = 1'b1;
            addr_d = cpu_addr;
            data_d = cpu_data;
        end else if (gnt_fill) begin
            we_d   = 1'b1;
            addr_d = base_q + i_q;
            data_d = value_q;
            i_d    = i_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    load    = 1'b1;
                    i_d     = '0;
                    state_d = (clr_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (gnt_fill && (i_q == len_q - AW'(1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (state_q == FILL);
        clr_done = (state_q == DONE);
        cpu_ack  = ack_q;
        vga_we   = we_q;
        vga_addr = addr_q;
        vga_data = data_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vram_arbiter;

    logic        clki = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [15:0] cpu_addr, cpu_data;
    logic        cpu_ack;
    logic        clr_start;
    logic [15:0] clr_base, clr_len, clr_value;
    logic        clr_busy, clr_done;
    logic        vram_rdy;
    logic        vga_we;
    logic [15:0] vga_addr, vga_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: remaining fill words, next fill address, pending done pulse,
    // round-robin pointer, and the write/ack expected on the port.
    int          m_left;
    logic [15:0] m_next, m_val;
    logic        m_done, m_prio;
    logic        m_we, m_ack;
    logic [15:0] m_addr, m_data;

    vram_arbiter #(.AW(16), .DW(16)) dut (
        .clki      (clki),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ack   (cpu_ack),
        .clr_start (clr_start),
        .clr_base  (clr_base),
        .clr_len   (clr_len),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vram_rdy  (vram_rdy),
        .vga_we    (vga_we),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data)
    );

    always #5 clki = ~clki;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_left = 0;
        m_next = '0;
        m_val  = '0;
        m_done = 1'b0;
        m_prio = 1'b0;
        m_we   = 1'b0;
        m_ack  = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic m_step();
        logic idle, cpu_v, fill_v, take_cpu;
        idle   = (m_left == 0) && !m_done;
        cpu_v  = cpu_req && !m_ack;
        fill_v = (m_left != 0);
        m_we   = 1'b0;
        m_ack  = 1'b0;
        m_done = 1'b0;
        if (vram_rdy && (cpu_v || fill_v)) begin
            take_cpu = cpu_v && (!fill_v || !m_prio);
            if (cpu_v && fill_v) m_prio = !m_prio;
            m_we = 1'b1;
            if (take_cpu) begin
                m_ack  = 1'b1;
                m_addr = cpu_addr;
                m_data = cpu_data;
            end else begin
                m_addr = m_next;
                m_data = m_val;
                m_next = m_next + 16'd1;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end
        if (idle && clr_start) begin
            m_val  = clr_value;
            m_next = clr_base;
            m_left = int'(clr_len);
            if (clr_len == 16'd0) m_done = 1'b1;
        end
    endtask

    always @(negedge clki) begin
        if (!rst_n) m_reset();
        chk("m_we",   32'(vga_we),   32'(m_we));
        chk("m_ack",  32'(cpu_ack),  32'(m_ack));
        chk("m_addr", 32'(vga_addr), 32'(m_addr));
        chk("m_data", 32'(vga_data), 32'(m_data));
        chk("m_busy", 32'(clr_busy), 32'(m_left != 0));
        chk("m_done", 32'(clr_done), 32'(m_done));
        if (rst_n) m_step();
    end

    task automatic tick();
        @(posedge clki);
        #2;
    endtask

    // Pulses an accepted start; returns in the cycle after the start (s+1).
    task automatic start_fill(input logic [15:0] base, input logic [15:0] len, input logic [15:0] val);
        clr_start = 1'b1;
        clr_base  = base;
        clr_len   = len;
        clr_value = val;
        tick();
        clr_start = 1'b0;
    endtask

    initial begin
        int nc, nf;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_data  = '0;
        clr_start = 1'b0;
        clr_base  = '0;
        clr_len   = '0;
        clr_value = '0;
        vram_rdy  = 1'b1;
        tick();
        tick();
        chk("rst_we",   32'(vga_we),   32'd0);
        chk("rst_addr", 32'(vga_addr), 32'd0);
        chk("rst_data", 32'(vga_data), 32'd0);
        chk("rst_ack",  32'(cpu_ack),  32'd0);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single CPU write; request stays high through the ack cycle.
        cpu_req  = 1'b1;
        cpu_addr = 16'h0100;
        cpu_data = 16'hABCD;
        tick();
        chk("cpu_we",   32'(vga_we),   32'd1);
        chk("cpu_addr", 32'(vga_addr), 32'h0100);
        chk("cpu_data", 32'(vga_data), 32'hABCD);
        chk("cpu_ack",  32'(cpu_ack),  32'd1);
        tick();
        chk("cpu_nodup_we",  32'(vga_we),  32'd0);
        chk("cpu_ack_pulse", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("cpu_idle_we", 32'(vga_we), 32'd0);

        // Uncontested fill of 4 words.
        start_fill(16'h0010, 16'd4, 16'h00E0);
        chk("fill4_busy_s1", 32'(clr_busy), 32'd1);
        chk("fill4_we_s1",   32'(vga_we),   32'd0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("fill4_we",   32'(vga_we),   32'd1);
            chk("fill4_addr", 32'(vga_addr), 32'h0010 + 32'(k) - 32'd2);
            chk("fill4_data", 32'(vga_data), 32'h00E0);
            chk("fill4_done", 32'(clr_done), 32'(k == 5));
            chk("fill4_busy", 32'(clr_busy), 32'(k != 5));
        end
        tick();
        chk("fill4_end_we",   32'(vga_we),   32'd0);
        chk("fill4_end_done", 32'(clr_done), 32'd0);

        // Three-cycle stall in the middle of a fill.
        start_fill(16'h0200, 16'd6, 16'h5555);
        tick();
        chk("stall_a0", 32'(vga_addr), 32'h0200);
        tick();
        chk("stall_a1", 32'(vga_addr), 32'h0201);
        vram_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_we", 32'(vga_we), 32'd0);
        end
        vram_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("resume_we",   32'(vga_we),   32'd1);
            chk("resume_addr", 32'(vga_addr), 32'h0202 + 32'(k));
            chk("resume_done", 32'(clr_done), 32'(k == 3));
        end

        // Address wrap, with starts offered during FILL and DONE.
        tick();
        start_fill(16'hFFFE, 16'd3, 16'h0F0F);
        tick();
        chk("wrap_a0", 32'(vga_addr), 32'hFFFE);
        clr_start = 1'b1;
        clr_base  = 16'h1234;
        clr_len   = 16'd5;
        tick();
        chk("wrap_a1", 32'(vga_addr), 32'hFFFF);
        clr_start = 1'b0;
        tick();
        chk("wrap_a2",   32'(vga_addr), 32'h0000);
        chk("wrap_we2",  32'(vga_we),   32'd1);
        chk("wrap_done", 32'(clr_done), 32'd1);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("ign_we0",   32'(vga_we),   32'd0);
        chk("ign_busy0", 32'(clr_busy), 32'd0);
        tick();
        chk("ign_busy1", 32'(clr_busy), 32'd0);
        chk("ign_done1", 32'(clr_done), 32'd0);

        // Zero-length fill.
        start_fill(16'h0AAA, 16'd0, 16'h1111);
        chk("len0_done", 32'(clr_done), 32'd1);
        chk("len0_busy", 32'(clr_busy), 32'd0);
        chk("len0_we",   32'(vga_we),   32'd0);
        tick();
        chk("len0_done_end", 32'(clr_done), 32'd0);
        chk("len0_we_end",   32'(vga_we),   32'd0);

        // Fill of 8 against a CPU that re-requests as soon as each ack arrives.
        start_fill(16'h0300, 16'd8, 16'h7777);
        nc = 0;
        nf = 0;
        cpu_req  = 1'b1;
        cpu_addr = 16'h9000;
        cpu_data = 16'hC000;
        for (int k = 2; k <= 18; k++) begin
            tick();
            if (k == 2) chk("contest_cpu_first", 32'(cpu_ack), 32'd1);
            if (vga_we && cpu_ack) begin
                chk("contest_cpu_addr", 32'(vga_addr), 32'h9000 + 32'(nc));
                chk("contest_cpu_data", 32'(vga_data), 32'hC000 + 32'(nc));
                nc++;
                cpu_addr = 16'h9000 + 16'(nc);
                cpu_data = 16'hC000 + 16'(nc);
                if (k >= 14) cpu_req = 1'b0;
            end else if (vga_we) begin
                chk("contest_fill_addr", 32'(vga_addr), 32'h0300 + 32'(nf));
                chk("contest_fill_data", 32'(vga_data), 32'h7777);
                nf++;
            end
        end
        cpu_req = 1'b0;
        chk("contest_fill_count", 32'(nf), 32'd8);
        chk("contest_cpu_count",  32'(nc), 32'd5);
        tick();

        // Reset in the middle of a 6-word fill.
        start_fill(16'h0400, 16'd6, 16'h1111);
        tick();
        chk("abort_a0", 32'(vga_addr), 32'h0400);
        tick();
        chk("abort_a1", 32'(vga_addr), 32'h0401);
        rst_n = 1'b0;
        #1;
        chk("abort_we",   32'(vga_we),   32'd0);
        chk("abort_busy", 32'(clr_busy), 32'd0);
        chk("abort_addr", 32'(vga_addr), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("abort_after_we",   32'(vga_we),   32'd0);
            chk("abort_after_done", 32'(clr_done), 32'd0);
        end
        start_fill(16'h0500, 16'd2, 16'h2222);
        tick();
        chk("refill_a0", 32'(vga_addr), 32'h0500);
        tick();
        chk("refill_a1",   32'(vga_addr), 32'h0501);
        chk("refill_done", 32'(clr_done), 32'd1);
        tick();

        // Randomized traffic; the per-cycle model does the checking.
        for (int c = 0; c < 3000; c++) begin
            tick();
            vram_rdy = ($urandom_range(3) != 0);
            if (!cpu_req || cpu_ack) begin
                cpu_req  = 1'($urandom_range(1));
                cpu_addr = 16'($urandom);
                cpu_data = 16'($urandom);
            end
            clr_start = ($urandom_range(15) == 0);
            if (clr_start) begin
                clr_base  = 16'($urandom);
                clr_len   = 16'($urandom_range(12));
                clr_value = 16'($urandom);
            end
        end
        cpu_req   = 1'b0;
        clr_start = 1'b0;
        vram_rdy  = 1'b1;
        for (int k = 0; k < 20; k++) tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
